// File: rtl/shift_reg_universal_n.sv
// Parametrised universal shift register with hold/shift/rotate/arith-shift/load modes
// and a burst sequencer that applies `count` shifts from one `start`.
module shift_reg_universal_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sr_in,
    input  logic             sl_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             sr_out,
    output logic             sl_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] ModeHold  = 3'b000;
    localparam logic [2:0] ModeShr   = 3'b001;
    localparam logic [2:0] ModeShl   = 3'b010;
    localparam logic [2:0] ModeLoad  = 3'b011;
    localparam logic [2:0] ModeRor   = 3'b100;
    localparam logic [2:0] ModeRol   = 3'b101;
    localparam logic [2:0] ModeAsr   = 3'b110;
    localparam logic [2:0] ModeHold2 = 3'b111;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] q_q;
    logic [CNT_W-1:0] rem_q;
    logic [2:0]       bmode_q;
    logic             done_q;
    logic             shift_mode;

    function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] v,
                                                 input logic [2:0]       m,
                                                 input logic [WIDTH-1:0] ld,
                                                 input logic             si_r,
                                                 input logic             si_l);
        logic [WIDTH-1:0] r;
        r = v;
        case (m)
            ModeShr:   r = {si_r, v[WIDTH-1:1]};
            ModeShl:   r = {v[WIDTH-2:0], si_l};
            ModeLoad:  r = ld;
            ModeRor:   r = {v[0], v[WIDTH-1:1]};
            ModeRol:   r = {v[WIDTH-2:0], v[WIDTH-1]};
            ModeAsr:   r = {v[WIDTH-1], v[WIDTH-1:1]};
            ModeHold,
            ModeHold2: r = v;
            default:   r = v;
        endcase
        return r;
    endfunction

    // Only genuine shift modes may start a burst; LOAD/hold with start act as direct mode.
    assign shift_mode = (mode == ModeShr) || (mode == ModeShl) || (mode == ModeRor) ||
                        (mode == ModeRol) || (mode == ModeAsr);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            q_q     <= '0;
            rem_q   <= '0;
            bmode_q <= ModeHold;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        if (start && shift_mode) begin
                            bmode_q <= mode;
                            rem_q   <= count;
                            if (count != '0) begin
                                state_q <= StRun;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end else begin
                            q_q <= step_fn(q_q, mode, d, sr_in, sl_in);
                        end
                    end
                end
                StRun: begin
                    if (en) begin
                        q_q   <= step_fn(q_q, bmode_q, d, sr_in, sl_in);
                        rem_q <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign q      = q_q;
    assign sr_out = q_q[0];
    assign sl_out = q_q[WIDTH-1];
    assign busy   = (state_q == StRun);
    assign done   = done_q;

endmodule

// File: tb/tb_shift_reg_universal_n.sv
// Scoreboard bench for shift_reg_universal_n: arithmetic reference model pushes expected
// post-edge state; a monitor pops and compares after every rising edge.
module tb_shift_reg_universal_n;

    logic       clk;
    logic       clr;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sr_in;
    logic       sl_in;
    logic       start;
    logic [3:0] count;
    logic [7:0] q;
    logic       sr_out;
    logic       sl_out;
    logic       busy;
    logic       done;

    typedef struct {
        int q;
        int busy;
        int done;
    } exp_t;

    exp_t exp_fifo[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state (plain integers)
    int m_q     = 0;
    int m_left  = 0;
    int m_bmode = 0;
    int m_done  = 0;

    shift_reg_universal_n #(
        .WIDTH(8),
        .CNT_W(4)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .sr_in  (sr_in),
        .sl_in  (sl_in),
        .start  (start),
        .count  (count),
        .q      (q),
        .sr_out (sr_out),
        .sl_out (sl_out),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic int apply(input int v, input int m, input int ld, input int sri,
                                 input int sli);
        case (m)
            1: return v / 2 + sri * 128;
            2: return (v * 2) % 256 + sli;
            3: return ld;
            4: return v / 2 + (v % 2) * 128;
            5: return (v * 2) % 256 + v / 128;
            6: return v / 2 + (v / 128) * 128;
            default: return v;
        endcase
    endfunction

    // Set inputs for the coming edge, advance the model, queue the expectation.
    task automatic drive(input logic c, input logic e, input logic [2:0] m, input logic [7:0] dd,
                         input logic sri, input logic sli, input logic st,
                         input logic [3:0] cnt);
        int nd;
        clr = c; en = e; mode = m; d = dd; sr_in = sri; sl_in = sli; start = st; count = cnt;
        nd = 0;
        if (c) begin
            m_q = 0; m_left = 0; m_bmode = 0;
        end else if (m_left > 0) begin
            if (e) begin
                m_q = apply(m_q, m_bmode, 0, int'(sri), int'(sli));
                m_left--;
                if (m_left == 0) nd = 1;
            end
        end else if (e) begin
            if (st && (m == 1 || m == 2 || m == 4 || m == 5 || m == 6)) begin
                m_bmode = int'(m);
                m_left  = int'(cnt);
                if (cnt == 0) nd = 1;
            end else begin
                m_q = apply(m_q, int'(m), int'(dd), int'(sri), int'(sli));
            end
        end
        m_done = nd;
        exp_fifo.push_back('{q: m_q, busy: (m_left > 0) ? 1 : 0, done: m_done});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic noise_run(input int n);
        // Inputs that must be ignored while a burst runs
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 4'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_fifo.size() > 0) begin
                e = exp_fifo.pop_front();
                check("q", int'(q), e.q);
                check("busy", int'(busy), e.busy);
                check("done", int'(done), e.done);
                check("sr_out", int'(sr_out), e.q % 2);
                check("sl_out", int'(sl_out), e.q / 128);
            end
        end
    end

    initial begin : stimulus
        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            drive(1'b1, 1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 4'($urandom));
        check("reset_q", int'(q), 0);
        drive(1'b0, 1'b1, 3'b011, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
        check("clr_during_shl", int'(q), 0);

        // Direct modes
        drive(1'b0, 1'b1, 3'b011, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0);
        check("load_a5", int'(q), 8'hA5);
        drive(1'b0, 1'b1, 3'b001, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0);
        check("shr_d2", int'(q), 8'hD2);
        drive(1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        check("shl_a4", int'(q), 8'hA4);
        drive(1'b0, 1'b1, 3'b111, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd0);
        check("hold7_a4", int'(q), 8'hA4);
        drive(1'b0, 1'b1, 3'b011, 8'h90, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        check("asr_c8", int'(q), 8'hC8);
        drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        check("asr_e4", int'(q), 8'hE4);

        // ROR burst of 3
        drive(1'b0, 1'b1, 3'b011, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
        check("ror_accept_q_held", int'(q), 8'h81);
        noise_run(3);
        check("ror_final", int'(q), 8'h30);
        idle(1);

        // ROL burst of 4 with a 2-cycle stall after the second shift
        drive(1'b0, 1'b1, 3'b011, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 1'b1, 4'd4);
        noise_run(2);
        drive(1'b0, 1'b0, 3'b011, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd0);
        drive(1'b0, 1'b0, 3'b011, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd0);
        noise_run(2);
        check("rol_stall_final", int'(q), 8'h10);
        idle(1);

        // count = 0, start with LOAD, back-to-back bursts
        drive(1'b0, 1'b1, 3'b001, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0);
        drive(1'b0, 1'b1, 3'b011, 8'h3C, 1'b0, 1'b0, 1'b1, 4'd7);
        check("start_load", int'(q), 8'h3C);
        drive(1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 1'b1, 4'd2);
        noise_run(2);
        drive(1'b0, 1'b1, 3'b001, 8'h00, 1'b1, 1'b0, 1'b1, 4'd1);
        noise_run(1);
        idle(1);

        // Abort: clr at the 2nd shift of a 5-shift burst
        drive(1'b0, 1'b1, 3'b011, 8'hF0, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5);
        noise_run(1);
        drive(1'b1, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        idle(3);

        // Randomised traffic
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 5) != 0),
                  3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 4) == 0), 4'($urandom));
        idle(20);

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_fifo.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
